tcb_full_arb: RTL and testbench
===============================

Name: tcb_full_arb

Overview:
- N-channel TCB-Full arbiter: multiplexes MAN_N manager channels onto one subordinate channel.
- Sits between several bus managers (CPU fetch/load-store, DMA) and one fixed-latency subordinate (memory, peripheral bridge).
- Adds round-robin or fixed-priority arbitration, frame locking via req.lck, and per-channel response routing and holding across a DLY-stage response pipeline.

Parameters:
- MAN_N, 2, number of manager channels (>=2).
- DLY, 1, subordinate response latency in cycles after transfer (>=0).
- HLD, 0, 1: each channel holds its last response until its next response; 0: response broadcast.
- ARB, TCB_ARB_RR, arbitration mode: TCB_ARB_RR round-robin, TCB_ARB_PRI fixed priority (index 0 highest).
- LCK, 1, 1: honour req.lck frame locking; 0: ignore req.lck.
- req_t, tcb_req_t, request struct type.
- rsp_t, tcb_rsp_t, response struct type.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- man_vld  input  MAN_N  per-channel request valid.
- man_rdy  output  MAN_N  per-channel ready.
- man_req  input  MAN_N x $bits(req_t)  per-channel request.
- man_rsp  output  MAN_N x $bits(rsp_t)  per-channel response.
- sub_vld  output  1  subordinate valid.
- sub_rdy  input  1  subordinate ready.
- sub_req  output  $bits(req_t)  subordinate request.
- sub_rsp  input  $bits(rsp_t)  subordinate response, valid DLY cycles after sub transfer.

Behaviour:
- IDX = max(1, $clog2(MAN_N)). Internal state: ptr[IDX], lck_act, lck_idx[IDX], dly_trn[1..DLY], dly_idx[1..DLY], and when HLD=1 a hold register per channel.
- Reset (rst=0, async): ptr=0, lck_act=0, lck_idx=0, all dly_trn=0, all hold registers='0. man_rdy=0 and sub_vld=0 while no man_vld is asserted.
- Grant, combinational in the same cycle (zero request latency):
  - lck_act=1: candidate set is {lck_idx} only.
  - TCB_ARB_PRI: lowest-index valid candidate wins.
  - TCB_ARB_RR: first valid candidate at or after ptr, searching modulo MAN_N.
- sub_vld = valid candidate exists. sub_req = man_req[gnt]. man_rdy[i] = sub_rdy & sub_vld & (gnt==i). Non-granted channels see rdy=0 and stall; their request must remain stable.
- ptr (RR only): on sub transfer, ptr <= (gnt+1) mod MAN_N. No change without a transfer. Does not advance while locked.
- Lock (LCK=1):
  - Sub transfer with sub_req.lck=1: lck_act<=1, lck_idx<=gnt.
  - Transfer with lck=0 from lck_idx: lck_act<=0.
  - Release and a competing request in the same cycle: the competitor can win only in the following cycle.
  - While locked and man_vld[lck_idx]=0: sub_vld=0; other channels stall.
- Response pipeline:
  - dly_trn[1]<=trn, dly_idx[1]<=gnt; each later stage shifts.
  - DLY=0 uses the current trn/gnt combinationally.
- Response output, HLD=0: man_rsp[i] = sub_rsp for all i. A channel's response content is defined only in the cycle where dly_trn[DLY]=1 and dly_idx[DLY]=i; at other times it is don't-care.
- Response output, HLD=1:
  - When dly_trn[DLY] and dly_idx[DLY]==i, man_rsp[i] = sub_rsp and hold[i]<=sub_rsp.
  - Otherwise man_rsp[i] = hold[i].
  - Other channels keep their held values.
- Back-to-back transfers from different channels each cycle are supported; the pipeline never stalls and throughput is 1 transfer per cycle.
- Reset mid-operation drops in-flight responses (dly_trn cleared) and clears the lock.
- MAN_N not a power of 2: ptr wraps from MAN_N-1 to 0, never holds an illegal value.

Decomposition:
- tcb_full_pkg: add enum tcb_arb_t {TCB_ARB_PRI, TCB_ARB_RR}.
- Sub-module tcb_full_arb_gnt: combinational grant from vld vector, ptr, lock mask and mode; outputs gnt index and a grant-valid flag. Reusable by future multi-subordinate crossbars.
- Pipeline, lock and hold logic stay in tcb_full_arb.

Test Plan:
- RR fairness: MAN_N=3, DLY=1, all man_vld=1 for 6 cycles, sub_rdy=1 -> grants 0,1,2,0,1,2; each man_rsp matches its own sub_rsp 1 cycle after its transfer.
- Priority starvation: ARB=TCB_ARB_PRI, ch0 and ch1 valid for 4 cycles -> ch0 granted all 4, man_rdy[1]=0 throughout, ch1 granted on the 5th cycle once ch0 drops.
- Lock frame: ch1 issues 3 transfers with lck=1,1,0 while ch0 is valid -> ch0 stalls for those 3 transfers, is granted the next cycle; lck_act clears after the lck=0 transfer.
- Hold + latency: HLD=1, DLY=2, ch0 transfer gets sub_rsp=0xA5 at cycle t+2, then ch1 transfer -> man_rsp[0] stays 0xA5 while man_rsp[1] updates.
- Back-pressure: sub_rdy=0 for 3 cycles with ch0/ch1 valid -> no transfer, ptr unchanged, no dly_trn; grant proceeds when sub_rdy=1.
- Async reset mid-frame: rst=0 mid-cycle with lock active and 2 transfers in flight -> outputs immediately reset; after release no stale response is routed, ptr=0, lock cleared.

Source files
------------

// File: rtl/tcb_full_pkg.sv
// Shared types for the TCB-Full arbiter family: arbitration modes, default
// request/response payloads and the index-width helper.
package tcb_full_pkg;

    typedef enum logic {
        TCB_ARB_PRI,
        TCB_ARB_RR
    } tcb_arb_t;

    typedef struct packed {
        logic        lck;
        logic        wen;
        logic [15:0] adr;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdt;
    } tcb_rsp_t;

    // Channel index width; a single bit even for degenerate channel counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_full_arb_gnt.sv
// Combinational grant selection: fixed priority or round-robin from ptr_i,
// optionally restricted to a single locked channel.
module tcb_full_arb_gnt
    import tcb_full_pkg::*;
#(
    parameter int unsigned MAN_N = 2,
    parameter tcb_arb_t    ARB   = TCB_ARB_RR,
    localparam int unsigned IDX  = idx_w(MAN_N)
) (
    input  logic [MAN_N-1:0] vld_i,
    input  logic [IDX-1:0]   ptr_i,
    input  logic             lck_act_i,
    input  logic [IDX-1:0]   lck_idx_i,
    output logic [IDX-1:0]   gnt_o,
    output logic             gnt_vld_o
);

    localparam logic [IDX:0] MAN_N_W = (IDX+1)'(MAN_N);

    logic [MAN_N-1:0] cand;

    always_comb begin
        cand = vld_i;
        if (lck_act_i) begin
            cand = vld_i & (MAN_N'(1) << lck_idx_i);
        end
    end

    generate
        if (ARB == TCB_ARB_PRI) begin : g_pri
            always_comb begin
                gnt_o     = '0;
                gnt_vld_o = 1'b0;
                for (int i = MAN_N - 1; i >= 0; i--) begin
                    if (cand[i]) begin
                        gnt_o     = IDX'(i);
                        gnt_vld_o = 1'b1;
                    end
                end
            end
        end else begin : g_rr
            logic [IDX:0] sum;

            // Walk offsets from the far end so the nearest candidate at/after ptr wins.
            always_comb begin
                gnt_o     = '0;
                gnt_vld_o = 1'b0;
                sum       = '0;
                for (int k = MAN_N - 1; k >= 0; k--) begin
                    sum = {1'b0, ptr_i} + (IDX+1)'(k);
                    if (sum >= MAN_N_W) begin
                        sum = sum - MAN_N_W;
                    end
                    if (cand[sum[IDX-1:0]]) begin
                        gnt_o     = sum[IDX-1:0];
                        gnt_vld_o = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tcb_full_arb.sv
// N-manager to one-subordinate TCB-Full arbiter with frame locking and
// per-channel response routing across a fixed-latency response pipeline.
module tcb_full_arb
    import tcb_full_pkg::*;
#(
    parameter int unsigned MAN_N = 2,
    parameter int unsigned DLY   = 1,
    parameter bit          HLD   = 1'b0,
    parameter tcb_arb_t    ARB   = TCB_ARB_RR,
    parameter bit          LCK   = 1'b1,
    parameter type         req_t = tcb_req_t,
    parameter type         rsp_t = tcb_rsp_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic       [MAN_N-1:0] man_vld,
    output logic       [MAN_N-1:0] man_rdy,
    input  req_t       [MAN_N-1:0] man_req,
    output rsp_t       [MAN_N-1:0] man_rsp,
    output logic                   sub_vld,
    input  logic                   sub_rdy,
    output req_t                   sub_req,
    input  rsp_t                   sub_rsp
);

    localparam int unsigned    IDX  = idx_w(MAN_N);
    localparam logic [IDX-1:0] LAST = IDX'(MAN_N - 1);

    logic [IDX-1:0] ptr_q, ptr_d;
    logic           lck_act_q, lck_act_d;
    logic [IDX-1:0] lck_idx_q, lck_idx_d;
    logic [IDX-1:0] gnt;
    logic           gnt_vld;
    logic           trn;

    tcb_full_arb_gnt #(
        .MAN_N (MAN_N),
        .ARB   (ARB)
    ) u_gnt (
        .vld_i     (man_vld),
        .ptr_i     (ptr_q),
        .lck_act_i (lck_act_q),
        .lck_idx_i (lck_idx_q),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld)
    );

    assign sub_vld = gnt_vld;
    assign sub_req = man_req[gnt];
    assign trn     = sub_vld & sub_rdy;

    generate
        for (genvar gi = 0; gi < MAN_N; gi++) begin : g_rdy
            assign man_rdy[gi] = trn & (gnt == IDX'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB == TCB_ARB_RR) && trn && !lck_act_q) begin
            ptr_d = (gnt == LAST) ? '0 : gnt + 1'b1;
        end
    end

    // A release only takes effect next cycle, so competitors cannot win the releasing cycle.
    always_comb begin
        lck_act_d = lck_act_q;
        lck_idx_d = lck_idx_q;
        if (LCK && trn) begin
            if (sub_req.lck) begin
                lck_act_d = 1'b1;
                lck_idx_d = gnt;
            end else if (lck_act_q && (gnt == lck_idx_q)) begin
                lck_act_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            lck_act_q <= 1'b0;
            lck_idx_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lck_act_q <= lck_act_d;
            lck_idx_q <= lck_idx_d;
        end
    end

    generate
        if (HLD) begin : g_hold
            logic           rsp_trn;
            logic [IDX-1:0] rsp_idx;

            if (DLY == 0) begin : g_dly0
                assign rsp_trn = trn;
                assign rsp_idx = gnt;
            end else begin : g_dly
                logic [DLY:1]   dly_trn_q;
                logic [IDX-1:0] dly_idx_q [1:DLY];

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        dly_trn_q <= '0;
                        for (int i = 1; i <= int'(DLY); i++) begin
                            dly_idx_q[i] <= '0;
                        end
                    end else begin
                        dly_trn_q[1] <= trn;
                        dly_idx_q[1] <= gnt;
                        for (int i = 2; i <= int'(DLY); i++) begin
                            dly_trn_q[i] <= dly_trn_q[i-1];
                            dly_idx_q[i] <= dly_idx_q[i-1];
                        end
                    end
                end

                assign rsp_trn = dly_trn_q[DLY];
                assign rsp_idx = dly_idx_q[DLY];
            end

            for (genvar gi = 0; gi < MAN_N; gi++) begin : g_ch
                rsp_t hold_q;
                logic hit;

                assign hit = rsp_trn && (rsp_idx == IDX'(gi));

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        hold_q <= '0;
                    end else if (hit) begin
                        hold_q <= sub_rsp;
                    end
                end

                assign man_rsp[gi] = hit ? sub_rsp : hold_q;
            end
        end else begin : g_bcast
            // Without holding, routing is implicit: every channel sees the live response.
            for (genvar gi = 0; gi < MAN_N; gi++) begin : g_ch
                assign man_rsp[gi] = sub_rsp;
            end
        end
    endgenerate

endmodule

// File: tb/tb_tcb_full_arb.sv
// Two arbiter configurations (round-robin/lock/hold/DLY=2 and fixed priority/DLY=0)
// driven with shared stimulus and checked against a cycle-level reference model.
module tb_tcb_full_arb;
    import tcb_full_pkg::*;

    localparam int N      = 3;
    localparam int RR_DLY = 2;
    localparam int NCYC   = 4096;

    logic                 clk = 1'b0;
    logic                 rst;
    logic     [N-1:0]     man_vld;
    tcb_req_t [N-1:0]     man_req;
    logic                 sub_rdy;
    tcb_rsp_t             sub_rsp;

    logic     [N-1:0]     rdy_rr, rdy_pri;
    tcb_rsp_t [N-1:0]     rsp_rr, rsp_pri;
    logic                 vld_rr, vld_pri;
    tcb_req_t             req_rr, req_pri;

    always #5 clk = ~clk;

    tcb_full_arb #(
        .MAN_N (N), .DLY (RR_DLY), .HLD (1'b1), .ARB (TCB_ARB_RR), .LCK (1'b1),
        .req_t (tcb_req_t), .rsp_t (tcb_rsp_t)
    ) u_rr (
        .clk (clk), .rst (rst),
        .man_vld (man_vld), .man_rdy (rdy_rr), .man_req (man_req), .man_rsp (rsp_rr),
        .sub_vld (vld_rr), .sub_rdy (sub_rdy), .sub_req (req_rr), .sub_rsp (sub_rsp)
    );

    tcb_full_arb #(
        .MAN_N (N), .DLY (0), .HLD (1'b0), .ARB (TCB_ARB_PRI), .LCK (1'b0),
        .req_t (tcb_req_t), .rsp_t (tcb_rsp_t)
    ) u_pri (
        .clk (clk), .rst (rst),
        .man_vld (man_vld), .man_rdy (rdy_pri), .man_req (man_req), .man_rsp (rsp_pri),
        .sub_vld (vld_pri), .sub_rdy (sub_rdy), .sub_req (req_pri), .sub_rsp (sub_rsp)
    );

    // Reference state for the round-robin instance
    int       m_ptr;
    bit       m_lck;
    int       m_lidx;
    tcb_rsp_t m_hold [N];
    int       sched  [NCYC];
    int       cyc;

    int       vec_cnt;
    int       err_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_lck  = 1'b0;
        m_lidx = 0;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        for (int i = cyc; i < NCYC; i++) sched[i] = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rr_vld"},  64'(vld_rr),  64'(0));
        chk({tag, "_rr_rdy"},  64'(rdy_rr),  64'(0));
        chk({tag, "_pri_vld"}, 64'(vld_pri), 64'(0));
        chk({tag, "_pri_rdy"}, 64'(rdy_pri), 64'(0));
        for (int i = 0; i < N; i++) chk($sformatf("%s_rr_rsp%0d", tag, i), 64'(rsp_rr[i]), 64'(0));
    endtask

    // Compare one cycle's combinational outputs, then advance the model as the clock edge will.
    task automatic check_commit();
        int          g_rr, g_pri, due, c;
        bit          v_rr, v_pri;
        logic [N-1:0] r_exp;
        tcb_rsp_t    rsp_exp;

        g_rr = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (g_rr < 0 && man_vld[c] && (!m_lck || c == m_lidx)) g_rr = c;
        end
        v_rr  = (g_rr >= 0);
        r_exp = (v_rr && sub_rdy) ? (N'(1) << g_rr) : '0;
        chk($sformatf("rr_sub_vld@%0d", cyc), 64'(vld_rr), 64'(v_rr));
        chk($sformatf("rr_man_rdy@%0d", cyc), 64'(rdy_rr), 64'(r_exp));
        if (v_rr) chk($sformatf("rr_sub_req@%0d", cyc), 64'(req_rr), 64'(man_req[g_rr]));

        due = sched[cyc];
        for (int i = 0; i < N; i++) begin
            rsp_exp = (due == i) ? sub_rsp : m_hold[i];
            chk($sformatf("rr_rsp%0d@%0d", i, cyc), 64'(rsp_rr[i]), 64'(rsp_exp));
        end
        if (due >= 0) m_hold[due] = sub_rsp;

        if (v_rr && sub_rdy) begin
            sched[cyc + RR_DLY] = g_rr;
            if (!m_lck) m_ptr = (g_rr + 1) % N;
            if (man_req[g_rr].lck) begin
                m_lck  = 1'b1;
                m_lidx = g_rr;
            end else begin
                m_lck = 1'b0;
            end
        end

        g_pri = -1;
        for (int i = 0; i < N; i++) if (g_pri < 0 && man_vld[i]) g_pri = i;
        v_pri = (g_pri >= 0);
        r_exp = (v_pri && sub_rdy) ? (N'(1) << g_pri) : '0;
        chk($sformatf("pri_sub_vld@%0d", cyc), 64'(vld_pri), 64'(v_pri));
        chk($sformatf("pri_man_rdy@%0d", cyc), 64'(rdy_pri), 64'(r_exp));
        if (v_pri) chk($sformatf("pri_sub_req@%0d", cyc), 64'(req_pri), 64'(man_req[g_pri]));
        if (v_pri && sub_rdy) chk($sformatf("pri_rsp@%0d", cyc), 64'(rsp_pri[g_pri]), 64'(sub_rsp));

        cyc++;
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] lck, input logic rdy);
        man_vld = vld;
        sub_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            man_req[i].lck = lck[i];
            man_req[i].wen = 1'($urandom_range(0, 1));
            man_req[i].adr = 16'($urandom);
            man_req[i].wdt = $urandom;
        end
        sub_rsp.rdt = $urandom;
        sub_rsp.err = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc     = 0;
        rst     = 1'b0;
        man_vld = '0;
        man_req = '0;
        sub_rdy = 1'b0;
        sub_rsp = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // Round-robin fairness: all channels requesting continuously
        repeat (6) drive(3'b111, 3'b000, 1'b1);

        // Back-pressure: nothing moves, pointer holds, then the grant proceeds
        repeat (3) drive(3'b011, 3'b000, 1'b0);
        drive(3'b011, 3'b000, 1'b1);

        // Priority starvation then the starved channel alone
        repeat (4) drive(3'b011, 3'b000, 1'b1);
        drive(3'b010, 3'b000, 1'b1);

        // Lock frame on ch1 (lck=1,1,0) with ch0 competing, then ch0 wins
        drive(3'b010, 3'b010, 1'b1);
        drive(3'b011, 3'b010, 1'b1);
        drive(3'b011, 3'b000, 1'b1);
        drive(3'b011, 3'b000, 1'b1);
        drive(3'b011, 3'b000, 1'b1);

        // Hold across latency: ch0 then ch1, then idle cycles keep held values
        drive(3'b001, 3'b000, 1'b1);
        drive(3'b010, 3'b000, 1'b1);
        repeat (4) drive(3'b000, 3'b000, 1'b1);

        // Locked frame on ch2 with two transfers in flight, then asynchronous reset
        drive(3'b100, 3'b100, 1'b1);
        drive(3'b111, 3'b100, 1'b1);
        drive(3'b111, 3'b100, 1'b1);
        #3;
        rst     = 1'b0;
        man_vld = '0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) drive(3'b111, 3'b000, 1'b1);
        repeat (3) drive(3'b000, 3'b000, 1'b1);

        // Randomized traffic with locking and back-pressure
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] v, l;
            v = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
            drive(v, l, ($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
